// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter.
// A granted byte is latched and presented on din with send_req until the
// transmitter answers with send_ack. After that the arbiter waits for send_ack
// to drop before it serves the next request.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   req          per-requester transmit request (level)
//   req_data     requester i byte at [i*DATA_SIZE +: DATA_SIZE]
//   req_ack      one-cycle pulse to the requester whose byte was accepted
//   grant        one-hot current owner, zero when idle
//   send_req     request to the transmitter
//   din          byte presented to the transmitter
//   send_ack     transmitter accept (level)
//   busy         high whenever the FSM is not idle
//   timeout_err  one-cycle pulse when the watchdog aborts a transfer
//
// Build option
//   UART_ARB_TIMEOUT_EN  enables the send_ack watchdog (TIMEOUT_CYCLES). When
//                        undefined, no counter is built, timeout_err is tied
//                        low and SEND waits forever.
//
// state       | meaning
// ST_IDLE     | no owner, searching for the next request
// ST_SEND     | byte latched, send_req high, waiting for send_ack
// ST_WAIT_LOW | byte accepted, waiting for send_ack to return low

module uart_tx_arbiter #(
    parameter int DATA_SIZE      = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           send_req,
    output logic [DATA_SIZE-1:0]           din,
    input  logic                           send_ack,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_last, w_last_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]   r_req_ack, w_req_ack_nxt;
    logic                 r_send_req, w_send_req_nxt;
    logic [DATA_SIZE-1:0] r_din, w_din_nxt;
    logic                 r_busy;

    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    int                   w_cand;
    logic                 w_wdog_tc;

    // Search upward from last+1, wrapping, so the previous owner comes last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req[IDX_W'(w_cand)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_cand);
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout_err;

    // Counter sits at zero outside SEND, so every entry to SEND starts fresh.
    // A send_ack on the terminal cycle wins over the abort.
    assign w_wdog_tc = (r_state == ST_SEND) && !send_ack &&
                       (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_wdog_tc;
            if (r_state != ST_SEND || w_wdog_tc)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wdog_tc   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_idx_nxt      = r_idx;
        w_grant_nxt    = r_grant;
        w_req_ack_nxt  = '0;
        w_send_req_nxt = r_send_req;
        w_din_nxt      = r_din;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_SEND;
                    w_idx_nxt      = w_pick;
                    w_grant_nxt    = NUM_REQ'(1) << w_pick;
                    w_din_nxt      = req_data[int'(w_pick)*DATA_SIZE +: DATA_SIZE];
                    w_send_req_nxt = 1'b1;
                end
            end
            ST_SEND: begin
                if (send_ack || w_wdog_tc) begin
                    w_state_nxt    = ST_WAIT_LOW;
                    w_req_ack_nxt  = NUM_REQ'(1) << r_idx;
                    w_grant_nxt    = '0;
                    w_send_req_nxt = 1'b0;
                    w_last_nxt     = r_idx;
                end
            end
            ST_WAIT_LOW: begin
                if (!send_ack)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_grant_nxt    = '0;
                w_send_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_idx      <= '0;
            r_grant    <= '0;
            r_req_ack  <= '0;
            r_send_req <= 1'b0;
            r_din      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_idx      <= w_idx_nxt;
            r_grant    <= w_grant_nxt;
            r_req_ack  <= w_req_ack_nxt;
            r_send_req <= w_send_req_nxt;
            r_din      <= w_din_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign req_ack  = r_req_ack;
    assign grant    = r_grant;
    assign send_req = r_send_req;
    assign din      = r_din;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_SIZE=8,
// TIMEOUT_CYCLES=16). Build with UART_ARB_TIMEOUT_EN defined to exercise the
// watchdog abort; without it the stalled transfer must keep send_req high.

module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        send_req;
    logic [7:0]  din;
    logic        send_ack;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .DATA_SIZE      (8),
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .grant       (grant),
        .send_req    (send_req),
        .din         (din),
        .send_ack    (send_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL time_limit: observed no end of test, expected summary before 100000 ns");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in IDLE with req already driven; the next edge must grant idx.
    // pre  : extra SEND cycles before send_ack rises
    // hold : extra cycles send_ack stays high after the accept
    // drop : requester releases req right after the grant
    task automatic xfer(input int idx, input logic [7:0] data, input int pre,
                        input int hold, input logic drop);
        @(posedge clk); #1;
        chk("grant", 32'(grant), 32'd1 << idx);
        chk("send_req_rise", 32'(send_req), 32'd1);
        chk("din", 32'(din), 32'(data));
        chk("busy_send", 32'(busy), 32'd1);
        chk("req_ack_send", 32'(req_ack), 32'd0);
        if (drop) req = 4'b0000;
        for (int p = 0; p < pre; p++) begin
            @(posedge clk); #1;
            chk("grant_hold", 32'(grant), 32'd1 << idx);
            chk("send_req_hold", 32'(send_req), 32'd1);
            chk("din_hold", 32'(din), 32'(data));
        end
        send_ack = 1'b1;
        @(posedge clk); #1;
        chk("req_ack_pulse", 32'(req_ack), 32'd1 << idx);
        chk("send_req_fall", 32'(send_req), 32'd0);
        chk("grant_clear", 32'(grant), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_send_req", 32'(send_req), 32'd0);
            chk("wait_req_ack", 32'(req_ack), 32'd0);
            chk("wait_grant", 32'(grant), 32'd0);
        end
        send_ack = 1'b0;
        @(posedge clk); #1;
        chk("req_ack_end", 32'(req_ack), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("send_req_idle", 32'(send_req), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 4'b0000;
        req_data = 32'hD3C2B1A5;
        send_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_send_req", 32'(send_req), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_req", 32'(busy), 32'd0);

        // Single requester 0, byte 0xA5.
        req = 4'b0001;
        xfer(0, 8'hA5, 2, 0, 1'b0);
        req = 4'b0000;

        // send_ack while idle is ignored.
        send_ack = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("ack_idle_busy", 32'(busy), 32'd0);
            chk("ack_idle_send_req", 32'(send_req), 32'd0);
            chk("ack_idle_req_ack", 32'(req_ack), 32'd0);
        end
        send_ack = 1'b0;

        // Reset in the middle of SEND for requester 2.
        req = 4'b0100;
        @(posedge clk); #1;
        chk("pre_rst_grant", 32'(grant), 32'd4);
        chk("pre_rst_send_req", 32'(send_req), 32'd1);
        reset_n = 1'b0;
        req     = 4'b0101;
        #1;
        chk("mid_rst_send_req", 32'(send_req), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ack", 32'(req_ack), 32'd0);
        #3;
        reset_n = 1'b1;
        xfer(0, 8'hA5, 0, 0, 1'b0);
        req = 4'b0000;

        // Fresh reset so last=3, then continuous 1111 rotation.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        req = 4'b1111;
        xfer(0, 8'hA5, 0, 0, 1'b0);
        xfer(1, 8'hB1, 0, 0, 1'b0);
        xfer(2, 8'hC2, 0, 0, 1'b0);
        xfer(3, 8'hD3, 0, 0, 1'b0);
        xfer(0, 8'hA5, 0, 0, 1'b0);

        // send_ack held 3 extra cycles after the accept.
        xfer(1, 8'hB1, 0, 3, 1'b0);
        xfer(2, 8'hC2, 0, 0, 1'b0);
        xfer(3, 8'hD3, 0, 0, 1'b0);

        // last=3 with req=1001 wraps to 0; req drops during SEND.
        req = 4'b1001;
        xfer(0, 8'hA5, 1, 0, 1'b1);

        // Stalled transfer for requester 1.
        req = 4'b0010;
        @(posedge clk); #1;
        chk("stall_grant", 32'(grant), 32'd2);
        chk("stall_send_req", 32'(send_req), 32'd1);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            chk("stall_send_req_hold", 32'(send_req), 32'd1);
            chk("stall_no_timeout", 32'(timeout_err), 32'd0);
        end
        @(posedge clk); #1;
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_timeout_err", 32'(timeout_err), 32'd1);
        chk("to_req_ack", 32'(req_ack), 32'd2);
        chk("to_send_req", 32'(send_req), 32'd0);
        chk("to_grant", 32'(grant), 32'd0);
        req = 4'b0000;
        @(posedge clk); #1;
        chk("to_err_pulse", 32'(timeout_err), 32'd0);
        chk("to_req_ack_pulse", 32'(req_ack), 32'd0);
        chk("to_busy_idle", 32'(busy), 32'd0);
`else
        chk("nto_send_req", 32'(send_req), 32'd1);
        chk("nto_timeout_err", 32'(timeout_err), 32'd0);
        chk("nto_grant", 32'(grant), 32'd2);
        send_ack = 1'b1;
        @(posedge clk); #1;
        chk("nto_req_ack", 32'(req_ack), 32'd2);
        send_ack = 1'b0;
        req = 4'b0000;
        @(posedge clk); #1;
        chk("nto_busy_idle", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, giving the byte width of each requester and of din.
REQ-002 SHALL have parameter NUM_REQ, default 4, giving the requester count (2..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000, giving the send_ack watchdog limit; used only under UART_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NUM_REQ bits: per-requester transmit request, level.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_SIZE bits: requester i byte in slice [i*DATA_SIZE +: DATA_SIZE].
REQ-008 SHALL have port req_ack, output, NUM_REQ bits: one-cycle pulse to the requester whose byte the transmitter accepted.
REQ-009 SHALL have port grant, output, NUM_REQ bits: one-hot current owner, all zeros when idle.
REQ-010 SHALL have port send_req, output, 1 bit: request to the UART transmitter.
REQ-011 SHALL have port din, output, DATA_SIZE bits: byte presented to the transmitter.
REQ-012 SHALL have port send_ack, input, 1 bit: transmitter accept, level.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when the watchdog aborts a transfer.

Function
REQ-015 SHALL implement states IDLE, SEND and WAIT_LOW, with all outputs registered.
REQ-016 In IDLE with req nonzero at edge t, SHALL select the first set req bit searching upward from (last+1) mod NUM_REQ, latch that requester's byte into din, set grant one-hot, assert send_req, and enter SEND; grant, din and send_req are visible in cycle t+1.
REQ-017 In SEND, SHALL hold send_req, din and grant stable until send_ack is sampled high.
REQ-018 On sampling send_ack high in SEND at edge s, SHALL in cycle s+1 pulse req_ack[granted] for exactly one cycle, deassert send_req, clear grant, set last to the granted index, and enter WAIT_LOW.
REQ-019 In WAIT_LOW, SHALL remain there while send_ack is high and SHALL return to IDLE on the first edge it is sampled low, so there is a minimum of one cycle with send_req low between transfers.
REQ-020 A requester SHALL keep req and its data stable until it sees req_ack, and SHALL drop req in the cycle after req_ack.
REQ-021 Deassertion of req[granted] during SEND SHALL be ignored; the latched byte completes.
REQ-022 Simultaneous requests SHALL be served round-robin; a continuously requesting set SHALL be served in strict rotation with no starvation.
REQ-023 The round-robin search SHALL wrap from index NUM_REQ-1 to index 0.
REQ-024 A single requester SHALL be granted back-to-back, with the minimum cycle count given by REQ-019.
REQ-025 A send_ack high in IDLE or WAIT_LOW SHALL be ignored.

Reset
REQ-026 On reset_n low, asynchronously and including mid-transfer, SHALL force state IDLE; req_ack, grant, send_req, din, busy and timeout_err to 0; last to NUM_REQ-1, so that requester 0 wins first; and the watchdog counter to 0.
REQ-027 An aborted byte SHALL NOT be retried after reset; its requester receives no req_ack.

Configuration
REQ-028 With UART_ARB_TIMEOUT_EN defined, SHALL count cycles spent in SEND and, when the count reaches TIMEOUT_CYCLES without send_ack, SHALL deassert send_req, clear grant, pulse timeout_err and req_ack[granted] together, update last, and go to WAIT_LOW.
REQ-029 Under UART_ARB_TIMEOUT_EN, the watchdog counter SHALL clear on every entry to SEND.
REQ-030 Without UART_ARB_TIMEOUT_EN, SHALL build no counter, SHALL tie timeout_err to 0, and SHALL wait in SEND indefinitely.

Verification
REQ-031 Bench SHALL cover: after reset, req=4'b0001, byte 0xA5 -> grant=0001, send_req=1 and din=0xA5 one cycle later; send_ack -> req_ack=0001 for exactly one cycle.
REQ-032 Bench SHALL cover: req=4'b1111 held continuously with acks -> grants in order 0,1,2,3,0 and each req_ack matching its grant.
REQ-033 Bench SHALL cover: last=3 and req=4'b1001 -> requester 0 granted (wrap-around).
REQ-034 Bench SHALL cover: reset_n pulsed low during SEND -> send_req, grant and busy at 0 immediately; no req_ack; next grant goes to requester 0.
REQ-035 Bench SHALL cover: send_ack held high for 3 cycles after accept -> stays in WAIT_LOW for 3 cycles, with send_req low throughout, before the next grant.
REQ-036 Bench SHALL cover, with UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: send_ack never asserted -> timeout_err and req_ack pulse together 16 cycles after send_req rises; without the macro, send_req stays high.
